// File: rtl/spi_sample_tx_if.sv
// Bus bundle for spi_sample_tx: the sample push from the filter, the SPI pins
// and the status outputs.
//   done/filtered : one-cycle sample strobe and its data word
//   sck/ce        : SPI clock and active-low chip enable from the MCU
//   sdo           : SPI data back to the MCU (CIPO)
//   ready         : at least one sample is buffered
//   overflow      : sticky, a sample was dropped on a full FIFO
// slave is the responder side; master is the filter/MCU side.
interface spi_sample_tx_if #(
  parameter int WIDTH = 32
);
  logic             done;
  logic [WIDTH-1:0] filtered;
  logic             sck;
  logic             ce;
  logic             sdo;
  logic             ready;
  logic             overflow;

  modport master (
    output done, filtered, sck, ce,
    input  sdo, ready, overflow
  );

  modport slave (
    input  done, filtered, sck, ce,
    output sdo, ready, overflow
  );
endinterface

// File: rtl/spi_sample_tx.sv
// SPI mode-0 responder that returns buffered filter samples to the MCU.
// Samples arrive on bus.done/bus.filtered into a DEPTH-word FIFO; each full
// SPI frame shifts the oldest word out MSB-first on bus.sdo and then pops it.
// Ports:
//   clk   : system clock (at least 8x the SCK rate)
//   reset : synchronous, active-high
//   bus   : spi_sample_tx_if.slave (done, filtered, sck, ce in;
//           sdo, ready, overflow out)
//
// state  | meaning
// IDLE   | no transfer; sdo held at 0, waiting for a ce falling edge
// SHIFT  | frame in progress; count sck rises, shift on sck falls
// HOLD   | all WIDTH bits sent; ignore sck until ce rises
module spi_sample_tx #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  spi_sample_tx_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // [0],[1] synchronise; [2] is the previous synced value for edge detect.
  logic [2:0]       sck_sync_q, sck_sync_d;
  logic [2:0]       ce_sync_q,  ce_sync_d;
  logic [1:0]       state_q,    state_d;
  logic [BIT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [WIDTH-1:0] shift_q,    shift_d;
  logic             empty_load_q, empty_load_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             ready_q,  ready_d;
  logic             overflow_q, overflow_d;

  logic             sck_rise, sck_fall, ce_rise, ce_fall;
  logic [BIT_W-1:0] bit_cnt_inc;
  logic             pop, push, full;

  assign sck_rise    =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall    = ~sck_sync_q[1] &  sck_sync_q[2];
  assign ce_rise     =  ce_sync_q[1]  & ~ce_sync_q[2];
  assign ce_fall     = ~ce_sync_q[1]  &  ce_sync_q[2];
  assign bit_cnt_inc = bit_cnt_q + BIT_W'(1);
  assign full        = (count_q == CNT_W'(DEPTH));

  // Transfer FSM
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    empty_load_d = empty_load_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ce_fall) begin
          // Head is only peeked here; it is popped once the full frame is out.
          shift_d      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
          empty_load_d = (count_q == '0);
          bit_cnt_d    = '0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ce_rise) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == BIT_W'(WIDTH)) begin
            pop     = ~empty_load_q;
            state_d = ST_HOLD;
          end
        end else if (sck_fall) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
        end
      end
      ST_HOLD: begin
        if (ce_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO; a push into a full FIFO is accepted when a pop frees a slot in the
  // same cycle.
  always_comb begin
    sck_sync_d = {sck_sync_q[1:0], bus.sck};
    ce_sync_d  = {ce_sync_q[1:0], bus.ce};
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push       = bus.done & (~full | pop);
    overflow_d = overflow_q | (bus.done & full & ~pop);
    ready_d    = (count_q != '0);
    if (push) begin
      mem_d[wr_ptr_q] = bus.filtered;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Synchronisers reset low so that a reset with ce held low does not look
  // like a fresh ce falling edge; the interrupted frame is then ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_q   <= '0;
      ce_sync_q    <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      empty_load_q <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      ce_sync_q    <= ce_sync_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      empty_load_q <= empty_load_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.sdo      = (state_q != ST_IDLE) & shift_q[WIDTH-1];
  assign bus.ready    = ready_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_spi_sample_tx.sv
module tb_spi_sample_tx;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_sample_tx_if #(.WIDTH(WIDTH)) bus();

  spi_sample_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model_q[$];
  logic        model_ovf;
  logic        rdy_at3, rdy_at4;

  typedef struct {
    logic        do_push;
    logic [31:0] push_word;
    int          nbits;
    logic [31:0] exp_word;
    logic        exp_rdy3;
    logic        exp_ready;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [31:0] w);
    if (model_q.size() == DEPTH) model_ovf = 1'b1;
    else model_q.push_back(w);
  endtask

  task automatic push_word(input logic [31:0] w);
    @(negedge clk);
    bus.done     = 1'b1;
    bus.filtered = w;
    @(negedge clk);
    bus.done     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  // MCU side of one frame: mode 0, sck at clk/10, sdo sampled just before
  // each rising edge. Optionally strobes a push exactly when the last rising
  // edge is acted on (third clk after the pin rises).
  task automatic spi_read(input int nbits, input logic last_push,
                          input logic [31:0] last_w, output logic [31:0] bits);
    bits = '0;
    @(negedge clk);
    bus.ce = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bits   = {bits[30:0], bus.sdo};
      bus.sck = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (i == nbits - 1) begin
          if (k == 2 && last_push) begin
            bus.done     = 1'b1;
            bus.filtered = last_w;
          end
          if (k == 3) begin
            bus.done = 1'b0;
            rdy_at3  = bus.ready;
          end
          if (k == 4) rdy_at4 = bus.ready;
        end
      end
      bus.sck = 1'b0;
      repeat (5) @(negedge clk);
    end
    bus.ce = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, exp;
    int          n;

    vecs[0] = '{1'b1, 32'hA5C3_0F81, 32, 32'hA5C3_0F81, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         32, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'hDEAD_BEEF, 10, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0,         32, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};

    reset        = 1'b1;
    bus.done     = 1'b0;
    bus.filtered = '0;
    bus.sck      = 1'b0;
    bus.ce       = 1'b1;
    model_ovf    = 1'b0;
    rdy_at3      = 1'b0;
    rdy_at4      = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_sdo", bus.sdo, 0);
    check("reset_ready", bus.ready, 0);
    check("reset_overflow", bus.overflow, 0);

    // Table-driven: single word, empty read, abort, read after abort.
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_push) push_word(vecs[i].push_word);
      repeat (2) @(negedge clk);
      spi_read(vecs[i].nbits, 1'b0, 32'h0, w);
      check($sformatf("vec%0d_data", i), w, vecs[i].exp_word >> (WIDTH - vecs[i].nbits));
      check($sformatf("vec%0d_ready_before_pop", i), rdy_at3, vecs[i].exp_rdy3);
      check($sformatf("vec%0d_ready_after_pop", i), rdy_at4, vecs[i].exp_ready);
      check($sformatf("vec%0d_ready", i), bus.ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_overflow", i), bus.overflow, vecs[i].exp_ovf);
      check($sformatf("vec%0d_sdo_idle", i), bus.sdo, 0);
    end

    // Overflow: fifth push is dropped and the flag is sticky.
    do_reset();
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    repeat (2) @(negedge clk);
    check("ovf_set", bus.overflow, 1);
    check("ovf_ready", bus.ready, 1);
    for (int i = 1; i <= 4; i++) begin
      spi_read(32, 1'b0, 32'h0, w);
      check($sformatf("ovf_read%0d", i), w, 32'(i));
      check($sformatf("ovf_sticky%0d", i), bus.overflow, 1);
    end
    check("ovf_drained_ready", bus.ready, 0);
    do_reset();
    check("ovf_cleared_by_reset", bus.overflow, 0);

    // Push on the same cycle as the final pop while full: accepted.
    for (int i = 1; i <= 4; i++) push_word(32'(i));
    spi_read(32, 1'b1, 32'h5, w);
    check("fullpp_read1", w, 32'h1);
    check("fullpp_overflow", bus.overflow, 0);
    for (int i = 2; i <= 5; i++) begin
      spi_read(32, 1'b0, 32'h0, w);
      check($sformatf("fullpp_read%0d", i), w, 32'(i));
    end
    check("fullpp_ready", bus.ready, 0);

    // Push and pop together with a single word buffered.
    push_word(32'h0000_0007);
    spi_read(32, 1'b1, 32'h0000_0008, w);
    check("one_pp_read", w, 32'h7);
    check("one_pp_ready_after", rdy_at4, 1);
    spi_read(32, 1'b0, 32'h0, w);
    check("one_pp_next", w, 32'h8);

    // Reset in the middle of a frame.
    push_word(32'h1234_5678);
    @(negedge clk);
    bus.ce = 1'b0;
    repeat (5) @(negedge clk);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      w = {w[30:0], bus.sdo};
      bus.sck = 1'b1;
      repeat (5) @(negedge clk);
      bus.sck = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("midrst_first16", w, 32'h0000_1234);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_sdo", bus.sdo, 0);
    check("midrst_ready", bus.ready, 0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      bus.sck = 1'b1;
      repeat (5) @(negedge clk);
      bus.sck = 1'b0;
      repeat (5) @(negedge clk);
      n = n + int'(bus.sdo);
    end
    check("midrst_sdo_ignored", 32'(n), 0);
    bus.ce = 1'b1;
    repeat (6) @(negedge clk);
    spi_read(32, 1'b0, 32'h0, w);
    check("midrst_next_read", w, 32'h0);
    check("midrst_ready_after", bus.ready, 0);

    // Randomized operations against a queue model.
    do_reset();
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) begin
            w = $urandom;
            push_word(w);
            model_push(w);
          end
          repeat (2) @(negedge clk);
        end
        1: begin
          exp = (model_q.size() != 0) ? model_q[0] : 32'h0;
          if (model_q.size() != 0) void'(model_q.pop_front());
          spi_read(32, 1'b0, 32'h0, w);
          check($sformatf("rnd%0d_read", it), w, exp);
        end
        2: begin
          n   = $urandom_range(1, 31);
          exp = (model_q.size() != 0) ? model_q[0] : 32'h0;
          spi_read(n, 1'b0, 32'h0, w);
          check($sformatf("rnd%0d_abort", it), w, exp >> (WIDTH - n));
        end
        default: begin
          logic [31:0] pw;
          pw  = $urandom;
          exp = (model_q.size() != 0) ? model_q[0] : 32'h0;
          if (model_q.size() != 0) void'(model_q.pop_front());
          model_push(pw);
          spi_read(32, 1'b1, pw, w);
          check($sformatf("rnd%0d_read_push", it), w, exp);
        end
      endcase
      check($sformatf("rnd%0d_ready", it), bus.ready, (model_q.size() != 0));
      check($sformatf("rnd%0d_overflow", it), bus.overflow, model_ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
